store_queue: RTL and testbench

- Initiator side of the data-memory store path for the dual-issue pipeline.
- Accepts up to two committed stores per cycle from lanes 1 and 2 and buffers them in program order.
- Drains exactly one store per cycle to the single data-memory write port, so dual same-cycle writes never reach the memory.
- Flags load/store byte-overlap hazards so the hazard unit stalls a load until conflicting stores have drained.

---
 rtl/mem_pkg.sv | 36 +++
 rtl/range_overlap.sv | 26 ++
 rtl/store_queue.sv | 143 ++++++++++++++
 tb/tb_store_queue.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared memory-path definitions: funct3 encodings, the queued store record
// and the access-size decode used for load/store overlap checks.
package mem_pkg;

    localparam int MEM_XLEN = 32;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic                valid;
        logic [MEM_XLEN-1:0] addr;
        logic [MEM_XLEN-1:0] data;
        logic [2:0]          funct3;
    } store_entry_t;

    // Byte count of an access; unknown encodings fall back to one byte.
    function automatic logic [2:0] access_size(input logic [2:0] funct3, input logic is_load);
        logic [2:0] sz;
        sz = 3'd1;
        case (funct3)
            F3_SH:   sz = 3'd2;
            F3_SW:   sz = 3'd4;
            F3_LHU:  sz = is_load ? 3'd2 : 3'd1;
            default: sz = 3'd1;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/range_overlap.sv
// Byte-range intersection test between one store and one load, computed one
// bit wider than the address so the range end never wraps.
module range_overlap #(
    parameter int AW = 17
) (
    input  logic [AW-1:0] s_addr,
    input  logic [2:0]    s_size,
    input  logic [AW-1:0] l_addr,
    input  logic [2:0]    l_size,
    output logic          overlap
);

    logic [AW:0] s_lo;
    logic [AW:0] s_hi;
    logic [AW:0] l_lo;
    logic [AW:0] l_hi;

    always_comb begin
        s_lo    = {1'b0, s_addr};
        l_lo    = {1'b0, l_addr};
        s_hi    = s_lo + (AW+1)'(s_size) - (AW+1)'(1);
        l_hi    = l_lo + (AW+1)'(l_size) - (AW+1)'(1);
        overlap = (s_lo <= l_hi) && (l_lo <= s_hi);
    end

endmodule

// File: rtl/store_queue.sv
// In-order store buffer: accepts up to two committed stores per cycle, drains
// one per cycle to the data memory and flags loads overlapping pending stores.
module store_queue
    import mem_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int ADDRESS_WIDTH = 17,
    parameter int DEPTH         = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     st_valid1,
    input  logic [XLEN-1:0]          st_addr1,
    input  logic [XLEN-1:0]          st_data1,
    input  logic [2:0]               st_funct3_1,
    input  logic                     st_valid2,
    input  logic [XLEN-1:0]          st_addr2,
    input  logic [XLEN-1:0]          st_data2,
    input  logic [2:0]               st_funct3_2,
    output logic                     st_ready,
    input  logic                     ld_valid1,
    input  logic [XLEN-1:0]          ld_addr1,
    input  logic [2:0]               ld_funct3_1,
    input  logic                     ld_valid2,
    input  logic [XLEN-1:0]          ld_addr2,
    input  logic [2:0]               ld_funct3_2,
    output logic                     ld_hazard1,
    output logic                     ld_hazard2,
    output logic                     mem_we,
    output logic [XLEN-1:0]          mem_addr,
    output logic [XLEN-1:0]          mem_wd,
    output logic [2:0]               mem_funct3,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

    store_entry_t  entries_q [DEPTH];
    store_entry_t  entries_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          enq_1, enq_2, deq;
    store_entry_t  head_entry;

    assign st_ready   = (count_q <= READY_MAX);
    assign enq_1      = st_valid1 & st_ready;
    assign enq_2      = st_valid2 & st_ready;
    assign deq        = (count_q != '0);
    assign head_entry = entries_q[head_q];

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        if (deq) begin
            entries_d[head_q].valid = 1'b0;
            head_d                  = head_q + PW'(1);
        end
        // With st_ready high, tail and tail+1 are always free, so they never alias head.
        if (enq_1) begin
            entries_d[tail_q] = '{valid: 1'b1, addr: MEM_XLEN'(st_addr1),
                                  data: MEM_XLEN'(st_data1), funct3: st_funct3_1};
        end
        if (enq_2) begin
            entries_d[enq_1 ? tail_q + PW'(1) : tail_q] =
                '{valid: 1'b1, addr: MEM_XLEN'(st_addr2),
                  data: MEM_XLEN'(st_data2), funct3: st_funct3_2};
        end
        tail_d  = tail_q + PW'(enq_1) + PW'(enq_2);
        count_d = count_q + CW'(enq_1) + CW'(enq_2) - CW'(deq);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entries_q <= '{default: '0};
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    assign mem_we     = deq;
    assign mem_addr   = deq ? XLEN'(head_entry.addr) : '0;
    assign mem_wd     = deq ? XLEN'(head_entry.data) : '0;
    assign mem_funct3 = deq ? head_entry.funct3 : 3'b000;
    assign count      = count_q;
    assign empty      = !deq;

    logic [2:0]       ld_size1, ld_size2, st1_size;
    logic [DEPTH-1:0] pend, hit1, hit2;
    logic             hit_st1;

    assign ld_size1 = access_size(ld_funct3_1, 1'b1);
    assign ld_size2 = access_size(ld_funct3_2, 1'b1);
    assign st1_size = access_size(st_funct3_1, 1'b0);

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic [2:0] e_size;
        assign e_size  = access_size(entries_q[i].funct3, 1'b0);
        assign pend[i] = entries_q[i].valid;

        range_overlap #(.AW(ADDRESS_WIDTH)) u_ov1 (
            .s_addr  (entries_q[i].addr[ADDRESS_WIDTH-1:0]),
            .s_size  (e_size),
            .l_addr  (ld_addr1[ADDRESS_WIDTH-1:0]),
            .l_size  (ld_size1),
            .overlap (hit1[i])
        );

        range_overlap #(.AW(ADDRESS_WIDTH)) u_ov2 (
            .s_addr  (entries_q[i].addr[ADDRESS_WIDTH-1:0]),
            .s_size  (e_size),
            .l_addr  (ld_addr2[ADDRESS_WIDTH-1:0]),
            .l_size  (ld_size2),
            .overlap (hit2[i])
        );
    end

    // Lane-1 store is older than the lane-2 load issued in the same cycle.
    range_overlap #(.AW(ADDRESS_WIDTH)) u_ov_st1 (
        .s_addr  (st_addr1[ADDRESS_WIDTH-1:0]),
        .s_size  (st1_size),
        .l_addr  (ld_addr2[ADDRESS_WIDTH-1:0]),
        .l_size  (ld_size2),
        .overlap (hit_st1)
    );

    assign ld_hazard1 = ld_valid1 & (|(pend & hit1));
    assign ld_hazard2 = ld_valid2 & ((|(pend & hit2)) | (st_valid1 & hit_st1));

    logic unused_ld_addr;
    assign unused_ld_addr = ^{ld_addr1[XLEN-1:ADDRESS_WIDTH], ld_addr2[XLEN-1:ADDRESS_WIDTH]};

endmodule

// File: tb/tb_store_queue.sv
// Randomized and directed bench for store_queue against a queue-based
// reference model of the store buffer.
module tb_store_queue;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  f3;
  } rec_t;

  logic        clk, rst_n;
  logic        st_valid1, st_valid2, ld_valid1, ld_valid2;
  logic [31:0] st_addr1, st_data1, st_addr2, st_data2, ld_addr1, ld_addr2;
  logic [2:0]  st_funct3_1, st_funct3_2, ld_funct3_1, ld_funct3_2;
  logic        st_ready, ld_hazard1, ld_hazard2, mem_we, empty;
  logic [31:0] mem_addr, mem_wd;
  logic [2:0]  mem_funct3;
  logic [3:0]  count;

  rec_t        model_q[$];
  logic [66:0] exp_q[$];
  rec_t        dut_wr_q[$];
  logic [7:0]  dut_mem[int unsigned];
  int          tests, errors, violations, max_cnt, saw_not_ready;

  store_queue #(.XLEN(32), .ADDRESS_WIDTH(17), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid1(st_valid1), .st_addr1(st_addr1), .st_data1(st_data1), .st_funct3_1(st_funct3_1),
    .st_valid2(st_valid2), .st_addr2(st_addr2), .st_data2(st_data2), .st_funct3_2(st_funct3_2),
    .st_ready(st_ready),
    .ld_valid1(ld_valid1), .ld_addr1(ld_addr1), .ld_funct3_1(ld_funct3_1),
    .ld_valid2(ld_valid2), .ld_addr2(ld_addr2), .ld_funct3_2(ld_funct3_2),
    .ld_hazard1(ld_hazard1), .ld_hazard2(ld_hazard2),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_funct3(mem_funct3),
    .count(count), .empty(empty)
  );

  // clock / reset
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int st_size(input logic [2:0] f3);
    if (f3 == 3'd1) return 2;
    if (f3 == 3'd2) return 4;
    return 1;
  endfunction

  function automatic int ld_size(input logic [2:0] f3);
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    if (f3 == 3'd2) return 4;
    return 1;
  endfunction

  function automatic bit ovl(input logic [31:0] s, input int ssz, input logic [31:0] l, input int lsz);
    int sa, la;
    sa = int'(s & 32'h1FFFF);
    la = int'(l & 32'h1FFFF);
    return (sa <= la + lsz - 1) && (la <= sa + ssz - 1);
  endfunction

  // reference model: pop one per edge, then append accepted stores in order
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_q.delete();
    end else begin
      int n;
      n = model_q.size();
      if (n > 0) exp_q.push_back(model_q.pop_front());
      if (n <= DEPTH - 2) begin
        if (st_valid1) model_q.push_back('{st_addr1, st_data1, st_funct3_1});
        if (st_valid2) model_q.push_back('{st_addr2, st_data2, st_funct3_2});
      end else if (st_valid1 || st_valid2) begin
        violations++;
      end
    end
  end

  // scoreboard compare, once per cycle away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      int n;
      bit h1, h2;
      n = model_q.size();
      if (int'(count) > max_cnt) max_cnt = int'(count);
      if (!st_ready) saw_not_ready = 1;
      chk("count", 67'(count), 67'(n));
      chk("empty", 67'(empty), 67'(n == 0));
      chk("st_ready", 67'(st_ready), 67'(n <= DEPTH - 2));
      chk("mem_we", 67'(mem_we), 67'(n != 0));
      if (n != 0) begin
        chk("mem_head", {mem_addr, mem_wd, mem_funct3}, model_q[0]);
      end
      if (mem_we) begin
        dut_wr_q.push_back('{mem_addr, mem_wd, mem_funct3});
        if (mem_funct3 <= 3'd2) begin
          for (int b = 0; b < st_size(mem_funct3); b++)
            dut_mem[mem_addr + 32'(b)] = mem_wd[8*b +: 8];
        end
      end
      h1 = 0;
      h2 = 0;
      foreach (model_q[i]) begin
        if (ovl(model_q[i].addr, st_size(model_q[i].f3), ld_addr1, ld_size(ld_funct3_1))) h1 = 1;
        if (ovl(model_q[i].addr, st_size(model_q[i].f3), ld_addr2, ld_size(ld_funct3_2))) h2 = 1;
      end
      if (st_valid1 && ovl(st_addr1, st_size(st_funct3_1), ld_addr2, ld_size(ld_funct3_2))) h2 = 1;
      chk("ld_hazard1", 67'(ld_hazard1), 67'(ld_valid1 && h1));
      chk("ld_hazard2", 67'(ld_hazard2), 67'(ld_valid2 && h2));
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    st_valid1 = 0; st_addr1 = 0; st_data1 = 0; st_funct3_1 = 0;
    st_valid2 = 0; st_addr2 = 0; st_data2 = 0; st_funct3_2 = 0;
    ld_valid1 = 0; ld_addr1 = 0; ld_funct3_1 = 0;
    ld_valid2 = 0; ld_addr2 = 0; ld_funct3_2 = 0;
  endtask

  task automatic set_st1(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    st_valid1 = 1; st_addr1 = a; st_data1 = d; st_funct3_1 = f;
  endtask

  task automatic set_st2(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    st_valid2 = 1; st_addr2 = a; st_data2 = d; st_funct3_2 = f;
  endtask

  task automatic check_addr_seq(input string name, input logic [31:0] base, input int n);
    chk({name, "_n"}, 67'(dut_wr_q.size()), 67'(n));
    for (int k = 0; k < n && k < dut_wr_q.size(); k++)
      chk(name, 67'(dut_wr_q[k].addr), 67'(base + 32'(4 * k)));
  endtask

  logic [31:0] pr_addr[4] = '{32'h204, 32'h200, 32'h205, 32'h1FC};
  logic [2:0]  pr_f3[4]   = '{3'b010, 3'b010, 3'b000, 3'b010};
  logic        pr_exp[4]  = '{1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    int wr_before, issued;
    logic [31:0] word;
    tests = 0; errors = 0; violations = 0; max_cnt = 0; saw_not_ready = 0;
    rst_n = 0;
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_empty", 67'(empty), 67'(1));
    chk("rst_count", 67'(count), 67'(0));
    chk("rst_mem_we", 67'(mem_we), 67'(0));
    chk("rst_st_ready", 67'(st_ready), 67'(1));
    chk("rst_mem_out", {mem_addr, mem_wd, mem_funct3}, 67'(0));
    chk("rst_hazards", 67'({ld_hazard1, ld_hazard2}), 67'(0));
    cyc();
    rst_n = 1;

    // reset with three stores queued
    set_st1(32'h800, 32'h1, 3'b010); set_st2(32'h804, 32'h2, 3'b010); cyc();
    set_st1(32'h808, 32'h3, 3'b010); set_st2(32'h80C, 32'h4, 3'b010); cyc();
    idle();
    chk("pre_rst_count", 67'(count), 67'(3));
    rst_n = 0;
    #1;
    chk("midrst_count", 67'(count), 67'(0));
    chk("midrst_empty", 67'(empty), 67'(1));
    chk("midrst_mem_we", 67'(mem_we), 67'(0));
    wr_before = dut_wr_q.size();
    cyc();
    rst_n = 1;
    repeat (5) cyc();
    chk("no_write_after_reset", 67'(dut_wr_q.size()), 67'(wr_before));

    // dual-store ordering and byte merge
    dut_wr_q.delete();
    dut_mem.delete();
    set_st1(32'h100, 32'hAABBCCDD, 3'b010);
    set_st2(32'h101, 32'h11, 3'b000);
    cyc();
    idle();
    repeat (4) cyc();
    chk("dual_n", 67'(dut_wr_q.size()), 67'(2));
    chk("dual_w0", dut_wr_q[0], {32'h100, 32'hAABBCCDD, 3'b010});
    chk("dual_w1", dut_wr_q[1], {32'h101, 32'h11, 3'b000});
    word = {dut_mem[32'h103], dut_mem[32'h102], dut_mem[32'h101], dut_mem[32'h100]};
    chk("dual_word", 67'(word), 67'(32'hAABB11DD));

    // fill to back-pressure
    dut_wr_q.delete();
    max_cnt = 0; saw_not_ready = 0; issued = 0;
    for (int c = 0; c < 60 && issued < 16; c++) begin
      idle();
      if (model_q.size() <= DEPTH - 2) begin
        set_st1(32'h400 + 32'(4 * issued), $urandom, 3'b010);
        set_st2(32'h404 + 32'(4 * issued), $urandom, 3'b010);
        issued += 2;
      end
      cyc();
    end
    idle();
    repeat (12) cyc();
    chk("fill_max_count", 67'(max_cnt), 67'(7));
    chk("fill_backpressure_seen", 67'(saw_not_ready), 67'(1));
    chk("fill_drained", 67'(count), 67'(0));
    check_addr_seq("fill_order", 32'h400, 16);

    // pointer wrap with single stores
    dut_wr_q.delete();
    max_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      idle();
      set_st1(32'(4 * k), $urandom, 3'b010);
      cyc();
    end
    idle();
    repeat (3) cyc();
    chk("wrap_max_count", 67'(max_cnt), 67'(1));
    check_addr_seq("wrap_order", 32'h0, 20);

    // hazard against a queued SH 0x203
    for (int p = 0; p < 4; p++) begin
      idle();
      set_st1(32'h203, 32'h5A5A, 3'b001);
      cyc();
      idle();
      ld_valid1 = 1; ld_addr1 = pr_addr[p]; ld_funct3_1 = pr_f3[p];
      ld_valid2 = 1; ld_addr2 = pr_addr[p]; ld_funct3_2 = pr_f3[p];
      @(negedge clk);
      chk("haz_lit1", 67'(ld_hazard1), 67'(pr_exp[p]));
      chk("haz_lit2", 67'(ld_hazard2), 67'(pr_exp[p]));
      cyc();
      idle();
    end

    // same-cycle ordering between lanes
    repeat (2) cyc();
    set_st1(32'h300, 32'hDEAD_BEEF, 3'b010);
    ld_valid2 = 1; ld_addr2 = 32'h302; ld_funct3_2 = 3'b000;
    @(negedge clk);
    chk("same_cycle_st1_ld2", 67'(ld_hazard2), 67'(1));
    cyc();
    idle();
    repeat (2) cyc();
    set_st2(32'h300, 32'hDEAD_BEEF, 3'b010);
    ld_valid1 = 1; ld_addr1 = 32'h302; ld_funct3_1 = 3'b000;
    @(negedge clk);
    chk("same_cycle_st2_ld1", 67'(ld_hazard1), 67'(0));
    cyc();
    idle();
    repeat (2) cyc();

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      idle();
      if (model_q.size() <= DEPTH - 2) begin
        if ($urandom_range(0, 1) == 1) set_st1(32'($urandom_range(0, 63)), $urandom, 3'($urandom_range(0, 7)));
        if ($urandom_range(0, 1) == 1) set_st2(32'($urandom_range(0, 63)), $urandom, 3'($urandom_range(0, 7)));
      end
      ld_valid1 = 1'($urandom_range(0, 1)); ld_addr1 = 32'($urandom_range(0, 70)); ld_funct3_1 = 3'($urandom_range(0, 7));
      ld_valid2 = 1'($urandom_range(0, 1)); ld_addr2 = 32'($urandom_range(0, 70)); ld_funct3_2 = 3'($urandom_range(0, 7));
      cyc();
    end
    idle();
    repeat (12) cyc();
    chk("final_empty", 67'(empty), 67'(1));
    chk("protocol_violations", 67'(violations), 67'(0));

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
